// File: rtl/radio_pll_sequencer.sv
// radio_pll_sequencer: sequences PLL power-up and settle, RX/TX chain turnaround
// and PLL ramp-down for the radio front end.
module radio_pll_sequencer #(
    parameter int SIZE_T_ARSTFS = 8,
    parameter int PRESCALE      = 16,
    parameter int TURNAROUND    = 4,
    parameter int RAMPDOWN      = 8
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     radioEnable,
    input  logic                     radioRxEn,
    input  logic [SIZE_T_ARSTFS-1:0] tArstFs,
    output logic                     pllEnable,
    output logic                     pllSettled,
    output logic                     rxChainEn,
    output logic                     txChainEn,
    output logic                     busy
);
    localparam int SETTLE_W = $clog2((2 ** SIZE_T_ARSTFS) * PRESCALE + 1);
    localparam int DLY_MAX  = (TURNAROUND > RAMPDOWN) ? TURNAROUND : RAMPDOWN;
    localparam int DLY_W    = $clog2(DLY_MAX + 1);
    localparam int CW       = (SETTLE_W > DLY_W) ? SETTLE_W : DLY_W;
    localparam logic [CW-1:0] TURN_LD = CW'(TURNAROUND - 1);
    localparam logic [CW-1:0] RAMP_LD = CW'(RAMPDOWN - 1);

    typedef enum logic [2:0] {IDLE, PLL_UP, SETTLED, TURN, RAMP_DOWN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rdy;
    logic          r_rx;
    logic          r_pll_en;
    logic          r_settled;
    logic          r_rx_en;
    logic          r_tx_en;
    logic          r_busy;
    logic [CW-1:0] w_settle_ld;
    logic          w_drop;

    assign w_settle_ld = CW'((32'(tArstFs) + 32'd1) * 32'(PRESCALE) - 32'd1);
    assign w_drop      = !radioEnable && (r_state == PLL_UP || r_state == SETTLED || r_state == TURN);

    assign pllEnable  = r_pll_en;
    assign pllSettled = r_settled;
    assign rxChainEn  = r_rx_en;
    assign txChainEn  = r_tx_en;
    assign busy       = r_busy;

    // r_rdy holds the FSM for one edge after reset release so no transition
    // can happen on the first edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rdy     <= 1'b0;
            r_rx      <= 1'b0;
            r_pll_en  <= 1'b0;
            r_settled <= 1'b0;
            r_rx_en   <= 1'b0;
            r_tx_en   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (r_rdy) begin
                if (w_drop) begin
                    r_state   <= RAMP_DOWN;
                    r_cnt     <= RAMP_LD;
                    r_settled <= 1'b0;
                    r_rx_en   <= 1'b0;
                    r_tx_en   <= 1'b0;
                end else begin
                    case (r_state)
                        IDLE: if (radioEnable) begin
                            r_state  <= PLL_UP;
                            r_cnt    <= w_settle_ld;
                            r_pll_en <= 1'b1;
                            r_busy   <= 1'b1;
                        end
                        PLL_UP, TURN: if (r_cnt == '0) begin
                            r_state   <= SETTLED;
                            r_settled <= 1'b1;
                            r_rx      <= radioRxEn;
                            r_rx_en   <= radioRxEn;
                            r_tx_en   <= !radioRxEn;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                        SETTLED: if (radioRxEn != r_rx) begin
                            r_state <= TURN;
                            r_cnt   <= TURN_LD;
                            r_rx_en <= 1'b0;
                            r_tx_en <= 1'b0;
                        end
                        RAMP_DOWN: if (r_cnt == '0) begin
                            r_state  <= IDLE;
                            r_pll_en <= 1'b0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/radio_pll_sequencer.md
RADIO_PLL_SEQUENCER -- requirements
Module: radio_pll_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have parameter SIZE_T_ARSTFS, default 8: width of the settle-time field.
REQ-003 SHALL have parameter PRESCALE, default 16: clock cycles per settle tick, minimum 1.
REQ-004 SHALL have parameter TURNAROUND, default 4: cycles both chains stay off on an RX/TX change, minimum 1.
REQ-005 SHALL have parameter RAMPDOWN, default 8: cycles pllEnable is held after a disable, minimum 1.
REQ-006 clk  input  1  system clock, rising edge.
REQ-007 rstN  input  1  asynchronous active-low reset.
REQ-008 radioEnable  input  1  radio on request, from timing engine stage 2.
REQ-009 radioRxEn  input  1  1 = RX, 0 = TX, from timing engine stage 2.
REQ-010 tArstFs  input  SIZE_T_ARSTFS  settle time in ticks.
REQ-011 pllEnable  output  1  PLL power/enable.
REQ-012 pllSettled  output  1  PLL settled status, returned to timing engine stage 1.
REQ-013 rxChainEn  output  1  RX analog chain enable.
REQ-014 txChainEn  output  1  TX analog chain enable.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, PLL_UP, SETTLED, TURN and RAMP_DOWN; all outputs SHALL be registered.
REQ-017 In IDLE with radioEnable=1 sampled at edge N, SHALL enter PLL_UP, with pllEnable=1 from edge N+1 onward.
REQ-018 SHALL capture tArstFs on the IDLE->PLL_UP transition; later changes SHALL have no effect on that cycle.
REQ-019 PLL_UP SHALL last exactly (captured tArstFs+1)*PRESCALE cycles, then enter SETTLED with pllSettled=1.
REQ-020 The settle counter SHALL be wide enough for (2^SIZE_T_ARSTFS)*PRESCALE without wrap.
REQ-021 In SETTLED, rxChainEn SHALL equal the radioRxEn value latched on entry, and txChainEn SHALL be its inverse.
REQ-022 In SETTLED, a change of radioRxEn from the latched value SHALL enter TURN on the next edge, with both chain enables 0.
REQ-023 TURN SHALL last exactly TURNAROUND cycles, then return to SETTLED with the new radioRxEn latched.
REQ-024 Further radioRxEn toggles during TURN SHALL be ignored; the value sampled on TURN exit SHALL win.
REQ-025 pllSettled SHALL stay 1 throughout TURN.
REQ-026 radioEnable=0 sampled in PLL_UP, SETTLED or TURN SHALL enter RAMP_DOWN on the next edge.
REQ-027 On entry to RAMP_DOWN, rxChainEn, txChainEn and pllSettled SHALL be 0 and pllEnable SHALL stay 1.
REQ-028 RAMP_DOWN SHALL last exactly RAMPDOWN cycles, then enter IDLE with pllEnable=0.
REQ-029 radioEnable=1 during RAMP_DOWN SHALL be ignored; if still 1 in IDLE, PLL_UP SHALL follow at the next edge.
REQ-030 Disable SHALL have priority over an RX/TX change when both occur in the same cycle.
REQ-031 rxChainEn and txChainEn SHALL never both be 1.
REQ-032 No chain enable SHALL be 1 while pllSettled=0.
REQ-033 tArstFs=0 SHALL give a settle time of PRESCALE cycles.

Reset
REQ-034 On rstN=0, asynchronously: state=IDLE; pllEnable, pllSettled, rxChainEn, txChainEn and busy SHALL all be 0; all counters SHALL be 0.
REQ-035 Reset mid-operation (any state) SHALL force the REQ-034 values immediately, with no ramp-down.
REQ-036 Reset release SHALL be synchronous-safe: the first state transition SHALL occur no earlier than the second rising edge after rstN rises.

Verification
REQ-037 PRESCALE=4, tArstFs=2, radioEnable rises before edge 0 with radioRxEn=1 -> pllEnable=1 at edge 1; pllSettled=1 and rxChainEn=1 at edge 13.
REQ-038 While SETTLED in RX, radioRxEn->0 -> both chains 0 for 4 cycles, then txChainEn=1; pllSettled stays 1 throughout.
REQ-039 radioEnable drops during PLL_UP at tick 1 -> pllSettled never asserts; pllEnable=1 for 8 more cycles, then IDLE and busy=0.
REQ-040 radioRxEn toggles and radioEnable drops in the same cycle while SETTLED -> RAMP_DOWN is entered and TURN is never entered.
REQ-041 rstN asserted while SETTLED in TX -> all outputs 0 within the same cycle; re-enable gives the full settle time again.
REQ-042 tArstFs=0 and tArstFs=255 with PRESCALE=16 -> settle time of 16 and 4096 cycles respectively.
